// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte and status out
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       busy;
    logic       ferr;

    modport master (input rx, output data, done, busy, ferr);
    modport slave  (output rx, input data, done, busy, ferr);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error flag
module uart_rx #(
    parameter int          width = 16,
    parameter int unsigned div   = 10417
) (
    input  logic      clk,
    input  logic      arst,
    uart_rx_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [width-1:0] half_last = width'((div >> 1) - 1);
    localparam logic [width-1:0] bit_last  = width'(div - 1);

    state_t           state, state_next;
    logic [width-1:0] cnt, cnt_next;
    logic [2:0]       bitn, bitn_next;
    logic [7:0]       sh, sh_next;
    logic [7:0]       data_next;
    logic             ferr_next, done_next;
    logic             rx_m, rx_s, rx_d;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            rx_d     <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            bitn     <= '0;
            sh       <= '0;
            bus.data <= '0;
            bus.ferr <= 1'b0;
            bus.done <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            rx_m     <= bus.rx;
            rx_s     <= rx_m;
            rx_d     <= rx_s;
            state    <= state_next;
            cnt      <= cnt_next;
            bitn     <= bitn_next;
            sh       <= sh_next;
            bus.data <= data_next;
            bus.ferr <= ferr_next;
            bus.done <= done_next;
            bus.busy <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + width'(1);
        bitn_next  = bitn;
        sh_next    = sh;
        data_next  = bus.data;
        ferr_next  = bus.ferr;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = '0;
                // Edge, not level: a line stuck low must not retrigger.
                if (rx_d && !rx_s) state_next = START;
            end
            START: begin
                if (cnt == half_last) begin
                    cnt_next = '0;
                    if (rx_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        bitn_next  = '0;
                    end
                end
            end
            DATA: begin
                if (cnt == bit_last) begin
                    cnt_next = '0;
                    sh_next  = {rx_s, sh[7:1]};
                    if (bitn == 3'd7) state_next = STOP;
                    else              bitn_next  = bitn + 3'd1;
                end
            end
            STOP: begin
                if (cnt == bit_last) begin
                    // Leaving at mid-stop-bit lets a back-to-back start edge be seen.
                    cnt_next   = '0;
                    data_next  = sh;
                    ferr_next  = ~rx_s;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx
module tb_uart_rx;
    localparam int div  = 16;
    localparam int half = div >> 1;
    localparam int lat  = 3 + half + 9 * div;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         start;
    } exp_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   done_cycs[$];
    bit   ignore = 1'b0;
    exp_t e;
    logic [7:0] prev_data = '0;
    logic       prev_ferr = 1'b0;
    logic       prev_done = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_if bus ();
    uart_rx #(.width(16), .div(div)) dut (.clk(clk), .arst(arst), .bus(bus));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit expect_it);
        @(negedge clk);
        if (expect_it) sb.push_back('{b, ~stop, cyc});
        bus.rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (div) @(negedge clk);
            bus.rx = b[i];
        end
        repeat (div) @(negedge clk);
        bus.rx = stop;
        repeat (div - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!arst) begin
            if (bus.done) begin
                done_cycs.push_back(cyc);
                check("busy_at_done", bus.busy, 0);
                if (prev_done) check("done_one_cycle", prev_done, 0);
                if (ignore) begin
                    check("aborted_byte_lost", bus.data == 8'h96, 0);
                end else if (sb.size() == 0) begin
                    check("unexpected_done", bus.done, 0);
                end else begin
                    e = sb.pop_front();
                    check("data", bus.data, e.data);
                    check("ferr", bus.ferr, e.ferr);
                    check("latency_ok", (cyc - e.start >= lat - 5) && (cyc - e.start <= lat + 5), 1);
                end
            end else begin
                if (bus.data !== prev_data) check("data_hold", bus.data, prev_data);
                if (bus.ferr !== prev_ferr) check("ferr_hold", bus.ferr, prev_ferr);
            end
        end
        prev_data = bus.data;
        prev_ferr = bus.ferr;
        prev_done = bus.done;
    end

    initial begin
        int t;
        int n0;
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        bus.rx = 1'b1;

        // Reset held: rx activity must not move any output.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            bus.rx = ~bus.rx;
            repeat (2) @(negedge clk);
            check("reset_vals", {bus.data, bus.done, bus.busy, bus.ferr}, 0);
        end
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        arst = 1'b0;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            send_frame(bytes[i], 1'b1, 1'b1);
            idle(div);
        end
        drain();

        // False start shorter than half a bit.
        n0 = done_cycs.size();
        @(negedge clk);
        t = cyc;
        bus.rx = 1'b0;
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
        check("fs_busy_rise", bus.busy, 1);
        for (int i = 0; i < 40 && bus.busy; i++) @(negedge clk);
        check("fs_busy_drop", bus.busy, 0);
        check("fs_drop_time_ok", (cyc - t) <= half + 4, 1);
        idle(2 * div);
        check("fs_no_done", done_cycs.size(), n0);
        check("fs_data", bus.data, 8'hFF);
        check("fs_ferr", bus.ferr, 0);

        send_frame(8'h5A, 1'b0, 1'b1);
        idle(2 * div);
        send_frame(8'hC3, 1'b1, 1'b1);
        idle(div);
        drain();

        // Reset at ~40% of a frame.
        n0 = done_cycs.size();
        fork
            send_frame(8'h96, 1'b1, 1'b0);
            begin
                repeat (64) @(negedge clk);
                #2 arst = 1'b1;
                #1 check("arst_vals", {bus.data, bus.done, bus.busy, bus.ferr}, 0);
                check("arst_no_done", done_cycs.size(), n0);
                #197 arst = 1'b0;
            end
        join
        check("arst_frame_no_done", done_cycs.size(), n0);
        ignore = 1'b1;
        idle(200);
        ignore = 1'b0;
        send_frame(8'h12, 1'b1, 1'b1);
        idle(2 * div);
        drain();

        n0 = done_cycs.size();
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1);
        idle(2 * div);
        drain();
        check("b2b_count", done_cycs.size() - n0, 2);
        if (done_cycs.size() >= n0 + 2) begin
            t = done_cycs[n0 + 1] - done_cycs[n0];
            check("b2b_spacing_ok", (t >= 10 * div - 2) && (t <= 10 * div + 2), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
